// File: rtl/tick_gen_multi_pkg.sv
// ---------------------------------------------------------------------------
// tick_gen_multi_pkg
// Shared definitions for the multi-channel clock-enable generator:
//   - ch_state_e    : per-channel FSM state encoding (IDLE=0, RUN=1)
//   - MODE_PERIODIC / MODE_ONESHOT : channel mode encoding
//   - clog2_min1()  : max(1, $clog2(v)), used for counter/select widths
// No ports (package).
// ---------------------------------------------------------------------------
package tick_gen_multi_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Width helper that never returns 0, so a single-value range still
    // gets a 1-bit vector.
    function automatic int clog2_min1(input int v);
        int c;
        c = $clog2(v);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/tick_gen_multi_channel.sv
// ---------------------------------------------------------------------------
// tick_gen_multi_channel
// One channel of the clock-enable generator: holds its period/mode
// registers, a down-counter of base ticks and a two-state FSM.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tick_i     : base tick from the shared prescaler (1 clk wide)
//   we_i       : write strobe for period_i/mode_i into this channel
//   period_i   : period in base ticks (0 is stored as 1)
//   mode_i     : 0 periodic, 1 one-shot
//   start_i    : arm / restart strobe
//   stop_i     : stop strobe (dominates start and tick)
//   ce_o       : registered channel enable, 1 clk wide, aligned with ce_base
//   state_o    : current FSM state (debug / busy decode)
//
// Strobe semantics: we_i, start_i and stop_i are sampled on every rising
// clk edge with no handshake back; a strobe high on an edge is acted on at
// that edge, and holding it high acts on every edge it is high.
// ---------------------------------------------------------------------------
module tick_gen_multi_channel
    import tick_gen_multi_pkg::*;
#(
    parameter int PW         = 16,
    parameter int DEF_PERIOD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_i,
    input  logic          we_i,
    input  logic [PW-1:0] period_i,
    input  logic          mode_i,
    input  logic          start_i,
    input  logic          stop_i,
    output logic          ce_o,
    output ch_state_e     state_o
);

    localparam logic [PW-1:0] DEF_P = (DEF_PERIOD == 0) ? PW'(1) : PW'(DEF_PERIOD);

    logic [PW-1:0] period_q, period_d;
    logic          mode_q, mode_d;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] reload_cnt;
    ch_state_e     state_q;
    logic          ce_q;

    // A write in the same cycle as a start/reload takes effect immediately,
    // so the FSM always reloads from the "next" period/mode.
    always_comb begin
        period_d = period_q;
        mode_d   = mode_q;
        if (we_i) begin
            period_d = (period_i == '0) ? PW'(1) : period_i;
            mode_d   = mode_i;
        end
    end

    // period_d is never 0, so this cannot wrap.
    assign reload_cnt = period_d - PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= DEF_P;
            mode_q   <= MODE_PERIODIC;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            ce_q     <= 1'b0;
        end else begin
            period_q <= period_d;
            mode_q   <= mode_d;
            ce_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        state_q <= ST_RUN;
                        cnt_q   <= reload_cnt;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        state_q <= ST_IDLE;
                    end else if (start_i) begin
                        cnt_q <= reload_cnt;
                    end else if (tick_i) begin
                        if (cnt_q == '0) begin
                            ce_q  <= 1'b1;
                            cnt_q <= reload_cnt;
                            if (mode_d == MODE_ONESHOT) begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - PW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ce_o    = ce_q;
    assign state_o = state_q;

endmodule

// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
// Multi-channel clock-enable generator. A shared prescaler divides clk by
// DIV = FCLK/FBASE into a base tick; NCH channels count base ticks against
// a runtime-programmable period and emit 1-clk enables (periodic/one-shot).
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   en         : global enable, 0 freezes prescaler and channel counters
//   ch_we      : period write strobe
//   ch_sel     : channel index for the write (out-of-range ignored)
//   ch_period  : period in base ticks (0 behaves as 1)
//   ch_mode    : 0 periodic, 1 one-shot
//   ch_start   : per-channel arm/restart strobe
//   ch_stop    : per-channel stop strobe
//   ce_base    : base tick, 1 clk high every DIV enabled clks
//   ce_out     : channel enables, coincide with ce_base
//   busy       : channel in RUN state
// DIV must be >= 1.
// ---------------------------------------------------------------------------
module tick_gen_multi
    import tick_gen_multi_pkg::*;
#(
    parameter int FCLK       = 50000000,
    parameter int FBASE      = 1000,
    parameter int NCH        = 4,
    parameter int PW         = 16,
    parameter int DEF_PERIOD = 1,
    localparam int CH_W      = clog2_min1(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            ch_we,
    input  logic [CH_W-1:0] ch_sel,
    input  logic [PW-1:0]   ch_period,
    input  logic            ch_mode,
    input  logic [NCH-1:0]  ch_start,
    input  logic [NCH-1:0]  ch_stop,
    output logic            ce_base,
    output logic [NCH-1:0]  ce_out,
    output logic [NCH-1:0]  busy
);

    localparam int DIV   = FCLK / FBASE;
    localparam int PRE_W = clog2_min1(DIV);
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pcnt_q;
    logic             ce_base_q;
    logic             tick_int;

    // Tick on the terminal count; with DIV=1 the counter sits at 0 and
    // ticks every enabled cycle.
    assign tick_int = en && (pcnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q    <= PRE_RELOAD;
            ce_base_q <= 1'b0;
        end else begin
            ce_base_q <= tick_int;
            if (tick_int) begin
                pcnt_q <= PRE_RELOAD;
            end else if (en) begin
                pcnt_q <= pcnt_q - PRE_W'(1);
            end
        end
    end

    assign ce_base = ce_base_q;

    ch_state_e ch_state [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic we_g;
        assign we_g = ch_we && (ch_sel == CH_W'(g));

        tick_gen_multi_channel #(
            .PW         (PW),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick_int),
            .we_i     (we_g),
            .period_i (ch_period),
            .mode_i   (ch_mode),
            .start_i  (ch_start[g]),
            .stop_i   (ch_stop[g]),
            .ce_o     (ce_out[g]),
            .state_o  (ch_state[g])
        );

        // State is a register, so busy is effectively registered too.
        assign busy[g] = (ch_state[g] == ST_RUN);
    end

endmodule
